servant_wbmux: RTL and testbench
================================

Name: servant_wbmux

Overview:
Parametrised Wishbone interconnect for the servant SoC. It connects one CPU master to NSLAVES slaves, selected by the top address bits. Unlike the fixed 3-target fake-ack mux, it waits for the real slave ack and registers the read data. It also flags error responses for unmapped slots and for slaves that never respond, which makes it usable with multi-cycle peripherals such as SPI flash and UARTs with wait states.

Parameters:
NSLAVES, 4, number of slave ports (1..16)
SEL_W, 2, address bits used as slave index: i_wb_cpu_adr[31 -: SEL_W]; requires 2**SEL_W >= NSLAVES
MAP_MASK, {NSLAVES{1'b1}}, bit n = 1 means slot n is populated; 0 means unmapped
TIMEOUT, 255, max cycles waiting for slave ack before error response; 0 disables timeout

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous reset, active low
i_wb_cpu_adr  in  32  master address
i_wb_cpu_dat  in  32  master write data
i_wb_cpu_sel  in  4  byte enables
i_wb_cpu_we  in  1  write enable
i_wb_cpu_cyc  in  1  cycle/strobe request
o_wb_cpu_rdt  out  32  registered read data
o_wb_cpu_ack  out  1  registered one-cycle ack
o_wb_cpu_err  out  1  high together with ack on error response
o_wb_s_adr  out  32  shared slave address (= i_wb_cpu_adr)
o_wb_s_dat  out  32  shared write data
o_wb_s_sel  out  4  shared byte enables
o_wb_s_we  out  1  shared write enable
o_wb_s_cyc  out  NSLAVES  per-slave cyc, at most one bit set
i_wb_s_rdt  in  32*NSLAVES  slave n read data at [32n+31:32n]
i_wb_s_ack  in  NSLAVES  per-slave ack

Behaviour:
- Reset (i_rst_n=0 at posedge): state=IDLE, o_wb_cpu_ack=0, o_wb_cpu_err=0, o_wb_cpu_rdt=0, timeout counter=0, latched index=0. o_wb_s_cyc=0 combinationally whenever state!=WAIT.
- Shared adr/dat/sel/we are pure combinational pass-through.
- Index idx = i_wb_cpu_adr[31 -: SEL_W].
- Slot n is valid iff idx<NSLAVES and MAP_MASK[n]=1.
- IDLE:
  - If i_wb_cpu_cyc & !o_wb_cpu_ack:
    - idx valid: latch idx, clear counter, go to WAIT.
    - idx invalid: next cycle ack=1, err=1, rdt=0; stay IDLE.
  - ack/err are single-cycle pulses, cleared the cycle after they are set.
- WAIT:
  - o_wb_s_cyc[latched idx] = i_wb_cpu_cyc.
  - i_wb_s_ack[latched idx]=1: next cycle ack=1, err=0, rdt=slave rdt (sampled on all transfers, including writes); go to IDLE.
  - !i_wb_cpu_cyc (master abort): go to IDLE, no ack; counter cleared.
  - TIMEOUT!=0 and counter==TIMEOUT-1 with no ack: next cycle ack=1, err=1, rdt=32'hDEADBEEF; go to IDLE.
  - Otherwise counter += 1. Counter width is $clog2(TIMEOUT+1), minimum 1, and never wraps.
  - Acks from non-selected slaves are ignored.
  - A slave ack in the same cycle as the timeout terminal count wins: err=0.
- Latency:
  - Valid slot, slave acks combinationally in its first WAIT cycle: cyc at T0 → WAIT at T1 → ack at T2.
  - Unmapped slot: ack at T1.
- Back-to-back: master may hold cyc high; the cycle in which ack=1 blocks a new start, so there is at least one idle cycle between transfers.
- Address is sampled at start only. Later adr changes during WAIT do not move o_wb_s_cyc.
- Reset mid-WAIT: o_wb_s_cyc drops the same cycle the reset is registered, and no ack is produced.

Test Plan:
- Defaults: slave 2 (adr=32'h8000_0010) acks on first WAIT cycle with rdt=32'h1234_5678 → o_wb_s_cyc=4'b0100 for 1 cycle; ack at T2 with rdt=32'h1234_5678, err=0.
- Slave 1 delays ack by 5 cycles on a write (we=1, dat=32'hA5A5_0001, sel=4'b0011) → s_cyc=4'b0010 held 6 cycles; shared dat/sel match; single ack pulse, err=0.
- MAP_MASK=4'b1011, access adr=32'h8000_0000 → no s_cyc asserted; ack+err at T1, rdt=0.
- TIMEOUT=8, slave 3 never acks → s_cyc[3] high for exactly 8 cycles; then ack+err with rdt=32'hDEADBEEF; next access to slave 0 completes normally.
- Master drops cyc after 2 WAIT cycles, then i_rst_n=0 during a later WAIT → no ack in either case; all outputs return to reset values; after release a read to slave 0 succeeds.
- NSLAVES=3, SEL_W=2, adr=32'hC000_0000 (idx 3 ≥ NSLAVES) → immediate err ack; a slave ack on a non-selected port during WAIT is ignored.

Source files
------------

// File: rtl/servant_wbmux_if.sv
// Wishbone bundle between the servant CPU, the interconnect and its slaves.
// Signal names keep the interconnect's point of view (i_ = into the mux).
interface servant_wbmux_if #(
    parameter int NSLAVES = 4
);
    logic [31:0]           i_wb_cpu_adr;
    logic [31:0]           i_wb_cpu_dat;
    logic [3:0]            i_wb_cpu_sel;
    logic                  i_wb_cpu_we;
    logic                  i_wb_cpu_cyc;
    logic [31:0]           o_wb_cpu_rdt;
    logic                  o_wb_cpu_ack;
    logic                  o_wb_cpu_err;
    logic [31:0]           o_wb_s_adr;
    logic [31:0]           o_wb_s_dat;
    logic [3:0]            o_wb_s_sel;
    logic                  o_wb_s_we;
    logic [NSLAVES-1:0]    o_wb_s_cyc;
    logic [32*NSLAVES-1:0] i_wb_s_rdt;
    logic [NSLAVES-1:0]    i_wb_s_ack;

    modport slave (
        input  i_wb_cpu_adr, i_wb_cpu_dat, i_wb_cpu_sel, i_wb_cpu_we, i_wb_cpu_cyc,
        input  i_wb_s_rdt, i_wb_s_ack,
        output o_wb_cpu_rdt, o_wb_cpu_ack, o_wb_cpu_err,
        output o_wb_s_adr, o_wb_s_dat, o_wb_s_sel, o_wb_s_we, o_wb_s_cyc
    );

    modport master (
        output i_wb_cpu_adr, i_wb_cpu_dat, i_wb_cpu_sel, i_wb_cpu_we, i_wb_cpu_cyc,
        output i_wb_s_rdt, i_wb_s_ack,
        input  o_wb_cpu_rdt, o_wb_cpu_ack, o_wb_cpu_err,
        input  o_wb_s_adr, o_wb_s_dat, o_wb_s_sel, o_wb_s_we, o_wb_s_cyc
    );
endinterface

// File: rtl/servant_wbmux.sv
// One-master / NSLAVES-slave Wishbone interconnect: waits for the real slave ack,
// registers read data, and answers unmapped slots and silent slaves with an error ack.
module servant_wbmux #(
    parameter int                 NSLAVES  = 4,
    parameter int                 SEL_W    = 2,
    parameter logic [NSLAVES-1:0] MAP_MASK = {NSLAVES{1'b1}},
    parameter int                 TIMEOUT  = 255
) (
    input logic             i_clk,
    input logic             i_rst_n,
    servant_wbmux_if.slave  wb
);
    localparam int NSLOT = 1 << SEL_W;
    localparam int CNT_W = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    // Slots above NSLAVES read as unmapped because the padding is zero.
    localparam logic [NSLOT-1:0] SLOT_OK = NSLOT'(MAP_MASK);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           r_state, w_next;
    logic [SEL_W-1:0] r_idx, w_idx_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic             r_ack, w_ack_nx;
    logic             r_err, w_err_nx;
    logic [31:0]      r_rdt, w_rdt_nx;

    logic [SEL_W-1:0] w_idx;
    logic [NSLOT-1:0] w_sack_pad;
    logic [NSLOT-1:0] w_cyc_pad;
    logic [31:0]      w_rdt_arr [NSLOT];

    assign w_idx      = wb.i_wb_cpu_adr[31 -: SEL_W];
    assign w_sack_pad = NSLOT'(wb.i_wb_s_ack);

    for (genvar g = 0; g < NSLOT; g++) begin : g_rdt
        if (g < NSLAVES) begin : g_real
            assign w_rdt_arr[g] = wb.i_wb_s_rdt[32*g +: 32];
        end else begin : g_pad
            assign w_rdt_arr[g] = '0;
        end
    end

    assign wb.o_wb_s_adr   = wb.i_wb_cpu_adr;
    assign wb.o_wb_s_dat   = wb.i_wb_cpu_dat;
    assign wb.o_wb_s_sel   = wb.i_wb_cpu_sel;
    assign wb.o_wb_s_we    = wb.i_wb_cpu_we;
    assign wb.o_wb_cpu_rdt = r_rdt;
    assign wb.o_wb_cpu_ack = r_ack;
    assign wb.o_wb_cpu_err = r_err;

    always_comb begin
        w_cyc_pad = '0;
        if (r_state == WAIT) w_cyc_pad[r_idx] = wb.i_wb_cpu_cyc;
    end
    assign wb.o_wb_s_cyc = w_cyc_pad[NSLAVES-1:0];

    always_comb begin
        w_next   = r_state;
        w_idx_nx = r_idx;
        w_cnt_nx = r_cnt;
        w_ack_nx = 1'b0;
        w_err_nx = 1'b0;
        w_rdt_nx = r_rdt;
        case (r_state)
            IDLE: begin
                // The ack cycle itself never starts a new transfer.
                if (wb.i_wb_cpu_cyc && !r_ack) begin
                    if (SLOT_OK[w_idx]) begin
                        w_idx_nx = w_idx;
                        w_cnt_nx = '0;
                        w_next   = WAIT;
                    end else begin
                        w_ack_nx = 1'b1;
                        w_err_nx = 1'b1;
                        w_rdt_nx = '0;
                    end
                end
            end
            WAIT: begin
                if (w_sack_pad[r_idx]) begin
                    w_ack_nx = 1'b1;
                    w_rdt_nx = w_rdt_arr[r_idx];
                    w_next   = IDLE;
                end else if (!wb.i_wb_cpu_cyc) begin
                    w_cnt_nx = '0;
                    w_next   = IDLE;
                end else if (TIMEOUT != 0 && r_cnt == TERM) begin
                    w_ack_nx = 1'b1;
                    w_err_nx = 1'b1;
                    w_rdt_nx = 32'hDEADBEEF;
                    w_next   = IDLE;
                end else if (r_cnt != '1) begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdt   <= '0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_nx;
            r_cnt   <= w_cnt_nx;
            r_ack   <= w_ack_nx;
            r_err   <= w_err_nx;
            r_rdt   <= w_rdt_nx;
        end
    end
endmodule

// File: tb/tb_servant_wbmux.sv
// Three interconnect variants (default / sparse map + short timeout / 3 slaves, no timeout)
// share one stimulus; a transaction-level model is checked every cycle.
module tb_servant_wbmux;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam int NEVER = 1000;
    localparam int NSL [3] = '{4, 4, 3};
    localparam logic [3:0] MSK [3] = '{4'b1111, 4'b1011, 4'b0111};
    localparam int TMO [3] = '{255, 8, 0};

    logic         rst_n;
    logic [31:0]  adr, dat;
    logic [3:0]   sel;
    logic         we;
    logic [2:0]   cyc;
    logic [3:0]   s_ack, ext_ack;
    logic [127:0] s_rdt;
    logic [31:0]  slv_data [4];
    int           dly [4];
    int           scnt [4];
    int           tests = 0, fails = 0;
    bit           chk_en = 1'b0;

    servant_wbmux_if #(.NSLAVES(4)) ifa ();
    servant_wbmux_if #(.NSLAVES(4)) ifb ();
    servant_wbmux_if #(.NSLAVES(3)) ifc ();

    assign ifa.i_wb_cpu_adr = adr;  assign ifb.i_wb_cpu_adr = adr;  assign ifc.i_wb_cpu_adr = adr;
    assign ifa.i_wb_cpu_dat = dat;  assign ifb.i_wb_cpu_dat = dat;  assign ifc.i_wb_cpu_dat = dat;
    assign ifa.i_wb_cpu_sel = sel;  assign ifb.i_wb_cpu_sel = sel;  assign ifc.i_wb_cpu_sel = sel;
    assign ifa.i_wb_cpu_we  = we;   assign ifb.i_wb_cpu_we  = we;   assign ifc.i_wb_cpu_we  = we;
    assign ifa.i_wb_cpu_cyc = cyc[0]; assign ifb.i_wb_cpu_cyc = cyc[1]; assign ifc.i_wb_cpu_cyc = cyc[2];
    assign ifa.i_wb_s_rdt = s_rdt;  assign ifb.i_wb_s_rdt = s_rdt;  assign ifc.i_wb_s_rdt = s_rdt[95:0];
    assign ifa.i_wb_s_ack = s_ack;  assign ifb.i_wb_s_ack = s_ack;  assign ifc.i_wb_s_ack = s_ack[2:0];

    servant_wbmux u_a (.i_clk(clk), .i_rst_n(rst_n), .wb(ifa.slave));
    servant_wbmux #(.NSLAVES(4), .SEL_W(2), .MAP_MASK(4'b1011), .TIMEOUT(8))
        u_b (.i_clk(clk), .i_rst_n(rst_n), .wb(ifb.slave));
    servant_wbmux #(.NSLAVES(3), .SEL_W(2), .MAP_MASK(3'b111), .TIMEOUT(0))
        u_c (.i_clk(clk), .i_rst_n(rst_n), .wb(ifc.slave));

    logic        o_ack [3], o_err [3];
    logic [31:0] o_rdt [3];
    logic [3:0]  o_scyc [3];
    logic [68:0] o_pass [3];
    assign o_ack[0] = ifa.o_wb_cpu_ack; assign o_ack[1] = ifb.o_wb_cpu_ack; assign o_ack[2] = ifc.o_wb_cpu_ack;
    assign o_err[0] = ifa.o_wb_cpu_err; assign o_err[1] = ifb.o_wb_cpu_err; assign o_err[2] = ifc.o_wb_cpu_err;
    assign o_rdt[0] = ifa.o_wb_cpu_rdt; assign o_rdt[1] = ifb.o_wb_cpu_rdt; assign o_rdt[2] = ifc.o_wb_cpu_rdt;
    assign o_scyc[0] = ifa.o_wb_s_cyc;  assign o_scyc[1] = ifb.o_wb_s_cyc;  assign o_scyc[2] = {1'b0, ifc.o_wb_s_cyc};
    assign o_pass[0] = {ifa.o_wb_s_adr, ifa.o_wb_s_dat, ifa.o_wb_s_sel, ifa.o_wb_s_we};
    assign o_pass[1] = {ifb.o_wb_s_adr, ifb.o_wb_s_dat, ifb.o_wb_s_sel, ifb.o_wb_s_we};
    assign o_pass[2] = {ifc.o_wb_s_adr, ifc.o_wb_s_dat, ifc.o_wb_s_sel, ifc.o_wb_s_we};

    // Bench slaves: slave n acks combinationally once it has seen cyc for dly[n] cycles.
    wire [3:0] any_scyc = o_scyc[0] | o_scyc[1] | o_scyc[2];
    always_comb begin
        s_rdt = '0;
        s_ack = ext_ack;
        for (int n = 0; n < 4; n++) begin
            s_rdt[32*n +: 32] = slv_data[n];
            if (any_scyc[n] && scnt[n] == dly[n]) s_ack[n] = 1'b1;
        end
    end
    always @(posedge clk)
        for (int n = 0; n < 4; n++) scnt[n] <= any_scyc[n] ? scnt[n] + 1 : 0;

    // Transaction model: busy/target/cycles-waited plus the response due next cycle.
    typedef struct {
        bit          busy;
        int          tgt;
        int          waited;
        logic        ack;
        logic        err;
        logic [31:0] rdt;
    } m_t;
    m_t m [3];

    function automatic m_t mstep(m_t s, int d);
        m_t n;
        int idx;
        n = s;
        n.ack = 1'b0;
        n.err = 1'b0;
        idx = int'(adr[31:30]);
        if (!rst_n) begin
            n.busy = 0; n.tgt = 0; n.waited = 0; n.rdt = '0;
        end else if (!s.busy) begin
            if (cyc[d] && !s.ack) begin
                if (idx < NSL[d] && MSK[d][idx]) begin
                    n.busy = 1; n.tgt = idx; n.waited = 0;
                end else begin
                    n.ack = 1; n.err = 1; n.rdt = '0;
                end
            end
        end else if (s_ack[s.tgt]) begin
            n.ack = 1; n.rdt = s_rdt[32*s.tgt +: 32]; n.busy = 0;
        end else if (!cyc[d]) begin
            n.busy = 0;
        end else if (TMO[d] != 0 && s.waited + 1 == TMO[d]) begin
            n.ack = 1; n.err = 1; n.rdt = 32'hDEADBEEF; n.busy = 0;
        end else begin
            n.waited = s.waited + 1;
        end
        return n;
    endfunction

    always @(posedge clk)
        for (int d = 0; d < 3; d++) m[d] <= mstep(m[d], d);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 3; d++) begin
                logic [3:0] es;
                es = (m[d].busy && cyc[d]) ? (4'b0001 << m[d].tgt) : 4'b0000;
                chk($sformatf("dut%0d ack", d), 128'(o_ack[d]), 128'(m[d].ack));
                chk($sformatf("dut%0d err", d), 128'(o_err[d]), 128'(m[d].err));
                chk($sformatf("dut%0d rdt", d), 128'(o_rdt[d]), 128'(m[d].rdt));
                chk($sformatf("dut%0d s_cyc", d), 128'(o_scyc[d]), 128'(es));
                chk($sformatf("dut%0d pass", d), 128'(o_pass[d]), 128'({adr, dat, sel, we}));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transfer on dut d; checks latency, response and how long any s_cyc stayed high.
    task automatic run(input string name, input int d, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input logic [3:0] sl, input int exp_lat,
                       input logic exp_err, input logic [31:0] exp_rdt, input int exp_cyc);
        int lat, ncyc;
        lat = 0; ncyc = 0;
        adr = a; we = w; dat = wd; sel = sl; cyc[d] = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (|o_scyc[d]) ncyc++;
            if (o_ack[d]) begin lat = n; break; end
        end
        chk({name, " latency"}, 128'(lat), 128'(exp_lat));
        chk({name, " err"}, 128'(o_err[d]), 128'(exp_err));
        chk({name, " rdt"}, 128'(o_rdt[d]), 128'(exp_rdt));
        chk({name, " s_cyc cycles"}, 128'(ncyc), 128'(exp_cyc));
        cyc[d] = 1'b0;
        step();
        chk({name, " ack pulse"}, 128'(o_ack[d]), 128'(0));
    endtask

    initial begin
        rst_n = 1'b0; adr = '0; dat = '0; sel = '0; we = 1'b0; cyc = '0; ext_ack = '0;
        slv_data[0] = 32'h0000_5A5A; slv_data[1] = 32'hCAFE_0001;
        slv_data[2] = 32'h1234_5678; slv_data[3] = 32'h3333_0003;
        for (int n = 0; n < 4; n++) dly[n] = NEVER;
        step();
        chk_en = 1'b1;
        step();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset dut%0d ack/err", d), 128'({o_ack[d], o_err[d]}), 128'(0));
            chk($sformatf("reset dut%0d rdt", d), 128'(o_rdt[d]), 128'(0));
            chk($sformatf("reset dut%0d s_cyc", d), 128'(o_scyc[d]), 128'(0));
        end
        rst_n = 1'b1;
        step();

        dly[2] = 0;
        run("A rd s2", 0, 32'h8000_0010, 1'b0, 32'h0, 4'hF, 2, 1'b0, 32'h1234_5678, 1);
        dly[1] = 5;
        run("A wr s1", 0, 32'h4000_0000, 1'b1, 32'hA5A5_0001, 4'b0011, 7, 1'b0, 32'hCAFE_0001, 6);

        run("B unmapped", 1, 32'h8000_0000, 1'b0, 32'h0, 4'hF, 1, 1'b1, 32'h0, 0);
        run("B timeout", 1, 32'hC000_0000, 1'b0, 32'h0, 4'hF, 9, 1'b1, 32'hDEADBEEF, 8);
        dly[0] = 0;
        run("B rd s0", 1, 32'h0000_0004, 1'b0, 32'h0, 4'hF, 2, 1'b0, 32'h0000_5A5A, 1);
        dly[3] = 7;
        run("B ack at terminal", 1, 32'hC000_0000, 1'b0, 32'h0, 4'hF, 9, 1'b0, 32'h3333_0003, 8);

        // Master abort after two WAIT cycles, then reset during a later WAIT.
        dly[0] = NEVER;
        adr = 32'h0000_0000; cyc[0] = 1'b1;
        step(); step();
        chk("abort s_cyc before drop", 128'(o_scyc[0]), 128'(4'b0001));
        cyc[0] = 1'b0;
        step();
        chk("abort no ack", 128'({o_ack[0], o_scyc[0]}), 128'(0));
        step();
        chk("abort still no ack", 128'(o_ack[0]), 128'(0));
        cyc[0] = 1'b1;
        step(); step();
        chk("pre-reset s_cyc", 128'(o_scyc[0]), 128'(4'b0001));
        rst_n = 1'b0;
        step();
        chk("reset s_cyc drop", 128'(o_scyc[0]), 128'(0));
        chk("reset clears rdt/ack", 128'({o_rdt[0], o_ack[0], o_err[0]}), 128'(0));
        cyc[0] = 1'b0; rst_n = 1'b1;
        step();
        dly[0] = 0;
        run("A rd s0 after reset", 0, 32'h0000_0000, 1'b0, 32'h0, 4'hF, 2, 1'b0, 32'h0000_5A5A, 1);

        run("C idx beyond", 2, 32'hC000_0000, 1'b0, 32'h0, 4'hF, 1, 1'b1, 32'h0, 0);
        dly[1] = 3;
        ext_ack = 4'b0101;
        run("C ignore foreign ack", 2, 32'h4000_0000, 1'b0, 32'h0, 4'hF, 5, 1'b0, 32'hCAFE_0001, 4);
        ext_ack = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
